vending_machine_param: RTL and testbench

Parametrised successor to the fixed-price candy vendor. It has configurable price and coin values, and a credit ceiling with coin rejection. It adds a cancel/refund path, change return, and a dispense handshake with the product dispenser. It sits between the coin acceptor front-end and the dispenser/change-return mechanics. All amounts are in units of 5 cents.

---
 rtl/vending_machine_param.sv | 113 +++++++++++
 tb/tb_vending_machine_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_param.sv
// Parametrised vending controller: collects coins up to a credit ceiling, dispenses
// with a request/acknowledge handshake and returns change or a cancelled credit.
module vending_machine_param #(
  parameter int CREDIT_W   = 4,
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 10,
  parameter int VAL1       = 1,
  parameter int VAL2       = 2,
  parameter int VAL3       = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                candy_ack,
  output logic                candy,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_RETURN} state_t;

  localparam logic [CREDIT_W:0]   MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_t                state, state_n;
  logic [CREDIT_W-1:0]   credit_q, credit_n;
  logic [CREDIT_W-1:0]   change_q, change_n;
  logic                  reject_q, reject_n;
  logic [CREDIT_W:0]     sum;

  function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] c);
    case (c)
      2'b01:   coin_value = (CREDIT_W+1)'(VAL1);
      2'b10:   coin_value = (CREDIT_W+1)'(VAL2);
      2'b11:   coin_value = (CREDIT_W+1)'(VAL3);
      default: coin_value = '0;
    endcase
  endfunction

  // One extra bit so credit plus the largest coin never wraps before the ceiling test.
  assign sum = {1'b0, credit_q} + coin_value(coin);

  always_comb begin
    state_n  = state;
    credit_n = credit_q;
    change_n = '0;
    reject_n = 1'b0;
    case (state)
      S_IDLE, S_COLLECT: begin
        if (cancel && state == S_COLLECT) begin
          state_n  = S_RETURN;
          change_n = credit_q;
          credit_n = '0;
          reject_n = (coin != 2'b00);
        end else if (coin != 2'b00) begin
          if (sum > MAX_W) begin
            reject_n = 1'b1;
          end else begin
            credit_n = sum[CREDIT_W-1:0];
            state_n  = (sum >= PRICE_W) ? S_VEND : S_COLLECT;
          end
        end
      end
      S_VEND: begin
        reject_n = (coin != 2'b00);
        if (candy_ack) begin
          credit_n = '0;
          if (credit_q > PRICE_C) begin
            state_n  = S_RETURN;
            change_n = credit_q - PRICE_C;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_RETURN: begin
        reject_n = (coin != 2'b00);
        credit_n = '0;
        state_n  = S_IDLE;
      end
      default: begin
        state_n  = S_IDLE;
        credit_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      credit_q <= '0;
      change_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state    <= state_n;
      credit_q <= credit_n;
      change_q <= change_n;
      reject_q <= reject_n;
    end
  end

  // change_q is only loaded on entry to RETURN, so it reads zero in every other cycle.
  assign candy        = (state == S_VEND);
  assign change_valid = (state == S_RETURN);
  assign change       = change_q;
  assign credit       = credit_q;
  assign coin_reject  = reject_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param: three parameterisations share one input stream and
// are compared each cycle against a purchase-level model, plus directed scenarios.
module tb_vending_machine_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin;
  logic       cancel;
  logic       candy_ack;

  logic       a_candy, a_cv, a_rej;
  logic [3:0] a_change, a_credit;
  logic       b_candy, b_cv, b_rej;
  logic [3:0] b_change, b_credit;
  logic       c_candy, c_cv, c_rej;
  logic [3:0] c_change, c_credit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vending_machine_param dut_a (
    .clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .candy_ack(candy_ack),
    .candy(a_candy), .change_valid(a_cv), .change(a_change), .credit(a_credit),
    .coin_reject(a_rej));

  vending_machine_param #(.MAX_CREDIT(6)) dut_b (
    .clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .candy_ack(candy_ack),
    .candy(b_candy), .change_valid(b_cv), .change(b_change), .credit(b_credit),
    .coin_reject(b_rej));

  vending_machine_param #(.PRICE(7), .CREDIT_W(4), .MAX_CREDIT(15)) dut_c (
    .clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .candy_ack(candy_ack),
    .candy(c_candy), .change_valid(c_cv), .change(c_change), .credit(c_credit),
    .coin_reject(c_rej));

  // Purchase-level view: "vending" means a product is owed, "refund" means money is
  // being handed back this cycle; collecting is simply credit > 0 while not vending.
  typedef struct {
    bit vending;
    bit refund;
    int amt;
    int credit;
    bit reject;
  } mst_t;

  mst_t ma, mb, mc;

  function automatic int value_of(input int c);
    case (c)
      1: return 1;
      2: return 2;
      3: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic mst_t step(input mst_t m, input int price, input int maxc,
                                input int c, input bit cx, input bit ack, input bit r);
    mst_t n;
    int   s;
    n = m;
    n.reject = 0;
    n.refund = 0;
    n.amt    = 0;
    if (r) begin
      n.vending = 0;
      n.credit  = 0;
      return n;
    end
    if (m.refund) begin
      n.credit = 0;
      n.reject = (c != 0);
      return n;
    end
    if (m.vending) begin
      n.reject = (c != 0);
      if (ack) begin
        n.vending = 0;
        if (m.credit > price) begin
          n.refund = 1;
          n.amt    = m.credit - price;
        end
        n.credit = 0;
      end
      return n;
    end
    if (cx && m.credit > 0) begin
      n.refund = 1;
      n.amt    = m.credit;
      n.credit = 0;
      n.reject = (c != 0);
      return n;
    end
    if (c != 0) begin
      s = m.credit + value_of(c);
      if (s > maxc) n.reject = 1;
      else begin
        n.credit = s;
        if (s >= price) n.vending = 1;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string p, input mst_t m, input logic cd, input logic cv,
                           input logic [3:0] ch, input logic [3:0] cr, input logic rj);
    check({p, "_candy"},  32'(cd), 32'(m.vending));
    check({p, "_cvalid"}, 32'(cv), 32'(m.refund));
    check({p, "_change"}, 32'(ch), 32'(m.refund ? m.amt : 0));
    check({p, "_credit"}, 32'(cr), 32'(m.credit));
    check({p, "_reject"}, 32'(rj), 32'(m.reject));
  endtask

  task automatic cycle(input bit r, input logic [1:0] c, input bit cx, input bit ack);
    rst = r; coin = c; cancel = cx; candy_ack = ack;
    @(posedge clk);
    #1;
    ma = step(ma, 3, 10, int'(c), cx, ack, r);
    mb = step(mb, 3, 6,  int'(c), cx, ack, r);
    mc = step(mc, 7, 15, int'(c), cx, ack, r);
    check_dut("a", ma, a_candy, a_cv, a_change, a_credit, a_rej);
    check_dut("b", mb, b_candy, b_cv, b_change, b_credit, b_rej);
    check_dut("c", mc, c_candy, c_cv, c_change, c_credit, c_rej);
  endtask

  initial begin
    bit         r, cx, ack;
    logic [1:0] c;
    ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};
    rst = 1'b1; coin = 2'b00; cancel = 1'b0; candy_ack = 1'b0;

    // Reset state
    cycle(1, 2'b00, 0, 0);
    check("rst_candy", 32'(a_candy), 32'd0);
    check("rst_credit", 32'(a_credit), 32'd0);
    check("rst_cvalid", 32'(a_cv), 32'd0);

    // Nickel + dime reaches exact price, ack without change
    cycle(0, 2'b01, 0, 0);
    check("tp1_credit1", 32'(a_credit), 32'd1);
    cycle(0, 2'b10, 0, 0);
    check("tp1_credit3", 32'(a_credit), 32'd3);
    check("tp1_candy", 32'(a_candy), 32'd1);
    cycle(0, 2'b00, 0, 0);
    cycle(0, 2'b00, 0, 1);
    check("tp1_candy_drop", 32'(a_candy), 32'd0);
    check("tp1_no_change", 32'(a_cv), 32'd0);
    check("tp1_credit0", 32'(a_credit), 32'd0);

    // Quarter overpays: change of 2 after ack
    cycle(1, 2'b00, 0, 0);
    cycle(0, 2'b11, 0, 0);
    check("tp2_credit5", 32'(a_credit), 32'd5);
    check("tp2_candy", 32'(a_candy), 32'd1);
    cycle(0, 2'b00, 0, 1);
    check("tp2_cvalid", 32'(a_cv), 32'd1);
    check("tp2_change", 32'(a_change), 32'd2);
    cycle(0, 2'b00, 0, 0);
    check("tp2_cvalid_off", 32'(a_cv), 32'd0);
    check("tp2_credit0", 32'(a_credit), 32'd0);

    // Cancel beats a simultaneous coin
    cycle(1, 2'b00, 0, 0);
    cycle(0, 2'b10, 0, 0);
    cycle(0, 2'b01, 1, 0);
    check("tp3_reject", 32'(a_rej), 32'd1);
    check("tp3_cvalid", 32'(a_cv), 32'd1);
    check("tp3_change", 32'(a_change), 32'd2);
    check("tp3_candy", 32'(a_candy), 32'd0);

    // Credit ceiling on the MAX_CREDIT=6 instance
    cycle(1, 2'b00, 0, 0);
    cycle(0, 2'b01, 0, 0);
    cycle(0, 2'b01, 0, 0);
    cycle(0, 2'b11, 0, 0);
    check("tp4_reject", 32'(b_rej), 32'd1);
    check("tp4_credit2", 32'(b_credit), 32'd2);
    cycle(0, 2'b01, 0, 0);
    check("tp4_credit3", 32'(b_credit), 32'd3);
    check("tp4_candy", 32'(b_candy), 32'd1);

    // Coin during VEND is refused, then reset before ack
    cycle(1, 2'b00, 0, 0);
    cycle(0, 2'b11, 0, 0);
    cycle(0, 2'b10, 0, 0);
    check("tp5_reject", 32'(a_rej), 32'd1);
    check("tp5_credit5", 32'(a_credit), 32'd5);
    cycle(1, 2'b00, 0, 0);
    check("tp5_candy", 32'(a_candy), 32'd0);
    check("tp5_credit0", 32'(a_credit), 32'd0);
    check("tp5_cvalid", 32'(a_cv), 32'd0);

    // PRICE=7 instance: two quarters, change of 3
    cycle(0, 2'b11, 0, 0);
    cycle(0, 2'b11, 0, 0);
    check("tp6_credit10", 32'(c_credit), 32'd10);
    check("tp6_candy", 32'(c_candy), 32'd1);
    cycle(0, 2'b00, 0, 1);
    check("tp6_cvalid", 32'(c_cv), 32'd1);
    check("tp6_change", 32'(c_change), 32'd3);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      c   = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      cx  = ($urandom_range(0, 7) == 0);
      ack = ($urandom_range(0, 3) == 0);
      cycle(r, c, cx, ack);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
